// File: rtl/data_bus_arbiter.sv
// Two-master arbiter for the shared data memory port: core (m0) wins ties, m1 is forced in after STARVE_LIM m0 wins.
// Optional transaction statistics counters are built when DATA_BUS_ARB_STATS_EN is defined.
module data_bus_arbiter #(
   parameter int unsigned AW         = 8,
   parameter int unsigned DW         = 8,
   parameter int unsigned MEM_LAT    = 1,
   parameter int unsigned STARVE_LIM = 3
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          m0_req_i,
   input  logic          m0_rw_i,
   input  logic [AW-1:0] m0_addr_i,
   input  logic [DW-1:0] m0_wdata_i,
   output logic [DW-1:0] m0_rdata_o,
   output logic          m0_ack_o,
   input  logic          m1_req_i,
   input  logic          m1_rw_i,
   input  logic [AW-1:0] m1_addr_i,
   input  logic [DW-1:0] m1_wdata_i,
   output logic [DW-1:0] m1_rdata_o,
   output logic          m1_ack_o,
   output logic          mem_en_o,
   output logic          mem_rw_o,
   output logic [AW-1:0] mem_addr_o,
   output logic [DW-1:0] mem_wdata_o,
   input  logic [DW-1:0] mem_rdata_i,
   output logic [1:0]    grant_o,
   output logic [15:0]   stat_m0_cnt_o,
   output logic [15:0]   stat_m1_cnt_o
);

   localparam int unsigned SW = 4;
   localparam int unsigned LW = 3;
   localparam int unsigned CW = 16;

   typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_WAIT, ST_DONE} state_e;

   state_e          state_q, state_d;
   logic [1:0]      grant_q, grant_d;
   logic            rw_q, rw_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [DW-1:0]   wdata_q, wdata_d;
   logic [SW-1:0]   starve_q, starve_d;
   logic [LW-1:0]   lat_q, lat_d;
   logic [DW-1:0]   m0_rdata_q, m0_rdata_d;
   logic [DW-1:0]   m1_rdata_q, m1_rdata_d;
   logic            mem_en_q, mem_en_d;
   logic            mem_rw_q, mem_rw_d;
   logic            m0_ack_q, m0_ack_d;
   logic            m1_ack_q, m1_ack_d;
   logic            pick_m1;

   // Next-state, capture and registered-output decode
   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      rw_d       = rw_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      starve_d   = starve_q;
      lat_d      = lat_q;
      m0_rdata_d = m0_rdata_q;
      m1_rdata_d = m1_rdata_q;
      pick_m1    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            grant_d = 2'b00;
            if (!m1_req_i) begin
               starve_d = '0;
            end
            if (m0_req_i || m1_req_i) begin
               pick_m1 = m1_req_i && (!m0_req_i || (starve_q == SW'(STARVE_LIM)));
               grant_d = {pick_m1, !pick_m1};
               rw_d    = pick_m1 ? m1_rw_i    : m0_rw_i;
               addr_d  = pick_m1 ? m1_addr_i  : m0_addr_i;
               wdata_d = pick_m1 ? m1_wdata_i : m0_wdata_i;
               if (pick_m1) begin
                  starve_d = '0;
               end else if (m1_req_i) begin
                  starve_d = starve_q + SW'(1);
               end
               state_d = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            lat_d   = LW'(MEM_LAT - 1);
            state_d = rw_q ? ST_DONE : ST_WAIT;
         end
         ST_WAIT: begin
            if (lat_q == '0) begin
               state_d = ST_DONE;
               if (grant_q[1]) begin
                  m1_rdata_d = mem_rdata_i;
               end else begin
                  m0_rdata_d = mem_rdata_i;
               end
            end else begin
               lat_d = lat_q - LW'(1);
            end
         end
         ST_DONE: begin
            grant_d = 2'b00;
            state_d = ST_IDLE;
         end
         default: begin
            grant_d = 2'b00;
            state_d = ST_IDLE;
         end
      endcase
      mem_en_d = (state_d == ST_ACCESS);
      mem_rw_d = (state_d == ST_ACCESS) && rw_d;
      m0_ack_d = (state_d == ST_DONE) && grant_d[0];
      m1_ack_d = (state_d == ST_DONE) && grant_d[1];
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q    <= ST_IDLE;
         grant_q    <= 2'b00;
         rw_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         starve_q   <= '0;
         lat_q      <= '0;
         m0_rdata_q <= '0;
         m1_rdata_q <= '0;
         mem_en_q   <= 1'b0;
         mem_rw_q   <= 1'b0;
         m0_ack_q   <= 1'b0;
         m1_ack_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         rw_q       <= rw_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         starve_q   <= starve_d;
         lat_q      <= lat_d;
         m0_rdata_q <= m0_rdata_d;
         m1_rdata_q <= m1_rdata_d;
         mem_en_q   <= mem_en_d;
         mem_rw_q   <= mem_rw_d;
         m0_ack_q   <= m0_ack_d;
         m1_ack_q   <= m1_ack_d;
      end
   end

   assign m0_rdata_o  = m0_rdata_q;
   assign m1_rdata_o  = m1_rdata_q;
   assign m0_ack_o    = m0_ack_q;
   assign m1_ack_o    = m1_ack_q;
   assign mem_en_o    = mem_en_q;
   assign mem_rw_o    = mem_rw_q;
   assign mem_addr_o  = addr_q;
   assign mem_wdata_o = wdata_q;
   assign grant_o     = grant_q;

`ifdef DATA_BUS_ARB_STATS_EN
   logic [CW-1:0] stat_m0_q, stat_m1_q;

   // Completed-transaction counters, saturating; they step as DONE is entered
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         stat_m0_q <= '0;
         stat_m1_q <= '0;
      end else begin
         if (m0_ack_d && (stat_m0_q != '1)) begin
            stat_m0_q <= stat_m0_q + CW'(1);
         end
         if (m1_ack_d && (stat_m1_q != '1)) begin
            stat_m1_q <= stat_m1_q + CW'(1);
         end
      end
   end

   assign stat_m0_cnt_o = stat_m0_q;
   assign stat_m1_cnt_o = stat_m1_q;
`else
   assign stat_m0_cnt_o = CW'(0);
   assign stat_m1_cnt_o = CW'(0);
`endif

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Directed bench for data_bus_arbiter: instance a uses MEM_LAT=1, instance b uses MEM_LAT=3.
module tb_data_bus_arbiter;

`ifdef DATA_BUS_ARB_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   logic       m0_req, m0_rw, m1_req, m1_rw;
   logic [7:0] m0_addr, m0_wdata, m1_addr, m1_wdata, mem_rdata;
   logic [7:0] m0_rdata, m1_rdata, mem_addr, mem_wdata;
   logic       m0_ack, m1_ack, mem_en, mem_rw;
   logic [1:0] grant;
   logic [15:0] st0, st1;

   logic       b_m0_req, b_m0_rw, b_m1_req, b_m1_rw;
   logic [7:0] b_m0_addr, b_m0_wdata, b_m1_addr, b_m1_wdata, b_mem_rdata;
   logic [7:0] b_m0_rdata, b_m1_rdata, b_mem_addr, b_mem_wdata;
   logic       b_m0_ack, b_m1_ack, b_mem_en, b_mem_rw;
   logic [1:0] b_grant;
   logic [15:0] b_st0, b_st1;

   logic [1:0] exp_g [8] = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b10};

   always #5 clk = ~clk;

   data_bus_arbiter #(.AW(8), .DW(8), .MEM_LAT(1), .STARVE_LIM(3)) u_dut_a (
      .clk_i(clk), .rst_ni(rst_n),
      .m0_req_i(m0_req), .m0_rw_i(m0_rw), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
      .m0_rdata_o(m0_rdata), .m0_ack_o(m0_ack),
      .m1_req_i(m1_req), .m1_rw_i(m1_rw), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
      .m1_rdata_o(m1_rdata), .m1_ack_o(m1_ack),
      .mem_en_o(mem_en), .mem_rw_o(mem_rw), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
      .mem_rdata_i(mem_rdata), .grant_o(grant),
      .stat_m0_cnt_o(st0), .stat_m1_cnt_o(st1)
   );

   data_bus_arbiter #(.AW(8), .DW(8), .MEM_LAT(3), .STARVE_LIM(3)) u_dut_b (
      .clk_i(clk), .rst_ni(rst_n),
      .m0_req_i(b_m0_req), .m0_rw_i(b_m0_rw), .m0_addr_i(b_m0_addr), .m0_wdata_i(b_m0_wdata),
      .m0_rdata_o(b_m0_rdata), .m0_ack_o(b_m0_ack),
      .m1_req_i(b_m1_req), .m1_rw_i(b_m1_rw), .m1_addr_i(b_m1_addr), .m1_wdata_i(b_m1_wdata),
      .m1_rdata_o(b_m1_rdata), .m1_ack_o(b_m1_ack),
      .mem_en_o(b_mem_en), .mem_rw_o(b_mem_rw), .mem_addr_o(b_mem_addr), .mem_wdata_o(b_mem_wdata),
      .mem_rdata_i(b_mem_rdata), .grant_o(b_grant),
      .stat_m0_cnt_o(b_st0), .stat_m1_cnt_o(b_st1)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      m0_req = 1'b1; m0_rw = 1'b1; m0_addr = 8'h55; m0_wdata = 8'h66;
      m1_req = 1'b0; m1_rw = 1'b0; m1_addr = 8'h00; m1_wdata = 8'h00;
      mem_rdata = 8'hEE;
      b_m0_req = 1'b0; b_m0_rw = 1'b0; b_m0_addr = 8'h00; b_m0_wdata = 8'h00;
      b_m1_req = 1'b0; b_m1_rw = 1'b0; b_m1_addr = 8'h00; b_m1_wdata = 8'h00;
      b_mem_rdata = 8'h3C;

      // Reset held two cycles with m0 requesting
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("rst_mem_en", 16'(mem_en), 16'h0);
         chk("rst_mem_rw", 16'(mem_rw), 16'h0);
         chk("rst_m0_ack", 16'(m0_ack), 16'h0);
         chk("rst_grant", 16'(grant), 16'h0);
         chk("rst_mem_addr", 16'(mem_addr), 16'h0);
         chk("rst_mem_wdata", 16'(mem_wdata), 16'h0);
         chk("rst_m0_rdata", 16'(m0_rdata), 16'h0);
         chk("rst_m1_rdata", 16'(m1_rdata), 16'h0);
         chk("rst_stat0", st0, 16'h0);
         chk("rst_stat1", st1, 16'h0);
      end
      rst_n = 1'b1;
      tick();
      chk("rel_mem_en", 16'(mem_en), 16'h1);
      chk("rel_mem_addr", 16'(mem_addr), 16'h55);
      tick();
      chk("rel_m0_ack", 16'(m0_ack), 16'h1);
      m0_req = 1'b0;
      tick();
      chk("idle_mem_en", 16'(mem_en), 16'h0);
      chk("idle_mem_rw", 16'(mem_rw), 16'h0);
      chk("idle_grant", 16'(grant), 16'h0);
      chk("idle_m0_ack", 16'(m0_ack), 16'h0);
      chk("idle_addr_hold", 16'(mem_addr), 16'h55);

      // m0 write 10 <- A5
      m0_req = 1'b1; m0_rw = 1'b1; m0_addr = 8'h10; m0_wdata = 8'hA5;
      tick();
      chk("wr_mem_en", 16'(mem_en), 16'h1);
      chk("wr_mem_rw", 16'(mem_rw), 16'h1);
      chk("wr_mem_addr", 16'(mem_addr), 16'h10);
      chk("wr_mem_wdata", 16'(mem_wdata), 16'hA5);
      chk("wr_grant", 16'(grant), 16'h1);
      chk("wr_ack_early", 16'(m0_ack), 16'h0);
      tick();
      chk("wr_m0_ack", 16'(m0_ack), 16'h1);
      chk("wr_m1_ack", 16'(m1_ack), 16'h0);
      chk("wr_done_mem_en", 16'(mem_en), 16'h0);
      m0_req = 1'b0;
      tick();
      chk("wr_ack_pulse", 16'(m0_ack), 16'h0);

      // m1 read 20, data 3C, on both latencies
      m1_req = 1'b1; m1_rw = 1'b0; m1_addr = 8'h20; mem_rdata = 8'h3C;
      b_m1_req = 1'b1; b_m1_rw = 1'b0; b_m1_addr = 8'h20;
      tick();
      chk("rd_mem_en", 16'(mem_en), 16'h1);
      chk("rd_mem_rw", 16'(mem_rw), 16'h0);
      chk("rd_mem_addr", 16'(mem_addr), 16'h20);
      chk("rd_grant", 16'(grant), 16'h2);
      chk("rd3_mem_en", 16'(b_mem_en), 16'h1);
      tick();
      chk("rd_wait_ack", 16'(m1_ack), 16'h0);
      chk("rd_wait_mem_en", 16'(mem_en), 16'h0);
      tick();
      chk("rd_m1_ack", 16'(m1_ack), 16'h1);
      chk("rd_m1_rdata", 16'(m1_rdata), 16'h3C);
      chk("rd_m0_ack", 16'(m0_ack), 16'h0);
      chk("rd3_ack_n3", 16'(b_m1_ack), 16'h0);
      m1_req = 1'b0;
      tick();
      chk("rd3_ack_n4", 16'(b_m1_ack), 16'h0);
      tick();
      chk("rd3_m1_ack", 16'(b_m1_ack), 16'h1);
      chk("rd3_m1_rdata", 16'(b_m1_rdata), 16'h3C);
      chk("rd3_m0_ack", 16'(b_m0_ack), 16'h0);
      b_m1_req = 1'b0;
      tick();
      chk("stat0_a", st0, STATS ? 16'd2 : 16'd0);
      chk("stat1_a", st1, STATS ? 16'd1 : 16'd0);

      // Reset during the WAIT of an m1 read
      m1_req = 1'b1; m1_rw = 1'b0; m1_addr = 8'h30; mem_rdata = 8'h77;
      tick();
      chk("abort_grant", 16'(grant), 16'h2);
      tick();
      m1_req = 1'b0;
      rst_n = 1'b0;
      tick();
      chk("abort_m1_ack", 16'(m1_ack), 16'h0);
      chk("abort_m1_rdata", 16'(m1_rdata), 16'h0);
      chk("abort_grant0", 16'(grant), 16'h0);
      chk("abort_mem_addr", 16'(mem_addr), 16'h0);
      chk("abort_stat0", st0, 16'h0);
      tick();
      chk("abort_m1_ack2", 16'(m1_ack), 16'h0);
      rst_n = 1'b1;
      tick();
      chk("abort_idle_ack", 16'(m1_ack), 16'h0);
      m1_req = 1'b1; m1_addr = 8'h21; mem_rdata = 8'h5A;
      tick();
      chk("post_mem_addr", 16'(mem_addr), 16'h21);
      tick();
      tick();
      chk("post_m1_ack", 16'(m1_ack), 16'h1);
      chk("post_m1_rdata", 16'(m1_rdata), 16'h5A);
      m1_req = 1'b0;
      tick();

      // Both masters writing back to back: m1 forced in after three m0 wins
      m0_req = 1'b1; m0_rw = 1'b1; m0_addr = 8'h40; m0_wdata = 8'h01;
      m1_req = 1'b1; m1_rw = 1'b1; m1_addr = 8'h41; m1_wdata = 8'h02;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk($sformatf("starve_grant%0d", i), 16'(grant), 16'(exp_g[i]));
         tick();
         chk($sformatf("starve_ack0_%0d", i), 16'(m0_ack), 16'(exp_g[i][0]));
         chk($sformatf("starve_ack1_%0d", i), 16'(m1_ack), 16'(exp_g[i][1]));
         if (i == 7) begin
            m0_req = 1'b0;
            m1_req = 1'b0;
         end
         tick();
      end
      chk("end_grant", 16'(grant), 16'h0);
      chk("end_m1_rdata_hold", 16'(m1_rdata), 16'h5A);
      chk("end_stat0", st0, STATS ? 16'd6 : 16'd0);
      chk("end_stat1", st1, STATS ? 16'd3 : 16'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
